// File: rtl/serial_add_ctrl_if.sv
// Handshake bundle for serial_add_ctrl: operand request (start/in_ready,
// A, B, Cin) and result delivery (out_valid/out_ready, SUM, COUT[, OVF]).
// master = requester/consumer side, slave = the adder controller.
// OVF exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] SUM;
    logic             COUT;
`ifdef SERIAL_ADD_OVF_EN
    logic             OVF;

    modport master (
        output start, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, COUT, OVF
    );
    modport slave (
        input  start, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, COUT, OVF
    );
`else
    modport master (
        output start, A, B, Cin, out_ready,
        input  in_ready, out_valid, SUM, COUT
    );
    modport slave (
        input  start, A, B, Cin, out_ready,
        output in_ready, out_valid, SUM, COUT
    );
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full_adder cell, LSB first, one bit/clk.
// Ports: clk, rst_n (async active-low), bus (serial_add_ctrl_if.slave:
//   start/in_ready/A/B/Cin in, out_valid/out_ready/SUM/COUT[/OVF] out).
// Macro SERIAL_ADD_OVF_EN adds the registered signed-overflow flag OVF.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_add_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_nxt;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             fa_s;
    logic             fa_co;
    logic             last;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter from the MSB so the LSB lands at bit 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_w1
            assign sum_nxt = fa_s;
        end else begin : g_wn
            assign sum_nxt = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_q;

    // Carry into the MSB is the carry flop on the final RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_q <= carry ^ fa_co;
        end
    end

    assign bus.OVF = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_sh        <= '0;
            b_sh        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh       <= bus.A;
                        b_sh       <= bus.B;
                        carry      <= bus.Cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_q <= sum_nxt;
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        cout_q      <= fa_co;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.SUM       = sum_q;
    assign bus.COUT      = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): vector table plus directed
// sequences for request blocking, DONE hold, and async reset abort.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand set and wait (bounded) for out_valid.
    task automatic accept_and_wait(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic cin);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 40) begin
            tick();
            cyc++;
        end
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Cin   = ~cin;
        check("in_ready_in_run", 32'(bus.in_ready), 32'd0);
        cyc = 0;
        while (!bus.out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(W));
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_after_ready", 32'(bus.out_valid), 32'd0);
        check("in_ready_after_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[6] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};

        bus.start     = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum", 32'(bus.SUM), 32'd0);
        check("rst_cout", 32'(bus.COUT), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            accept_and_wait(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("vec%0d_sum", i), 32'(bus.SUM), 32'(vecs[i].sum));
            check($sformatf("vec%0d_cout", i), 32'(bus.COUT),
                  32'(vecs[i].cout));
`ifdef SERIAL_ADD_OVF_EN
            check($sformatf("vec%0d_ovf", i), 32'(bus.OVF), 32'(vecs[i].ovf));
`endif
            release_result();
        end

        // Start pulses in RUN and DONE must be ignored.
        bus.A     = 8'h10;
        bus.B     = 8'h20;
        bus.Cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.A     = 8'hAA;
        bus.B     = 8'h55;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("run_start_ignored", 32'(bus.in_ready), 32'd0);
        begin
            int cyc;
            cyc = 0;
            while (!bus.out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            check("blk_valid_seen", 32'(bus.out_valid), 32'd1);
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("done_start_in_ready", 32'(bus.in_ready), 32'd0);
        check("blk_sum", 32'(bus.SUM), 32'h30);
        check("blk_cout", 32'(bus.COUT), 32'd0);

        // Hold in DONE for 5 cycles: result must stay put.
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("hold%0d_sum", i), 32'(bus.SUM), 32'h30);
            check($sformatf("hold%0d_cout", i), 32'(bus.COUT), 32'd0);
        end

        // out_ready together with start: leave DONE, do not accept.
        bus.A         = 8'hAA;
        bus.B         = 8'h55;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        check("rdy_start_valid", 32'(bus.out_valid), 32'd0);
        check("rdy_start_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("rdy_start_not_taken", 32'(bus.in_ready), 32'd1);

        // Leave COUT=1 so the reset abort is observable on it.
        accept_and_wait(8'hFF, 8'h01, 1'b0);
        check("pre_rst_cout", 32'(bus.COUT), 32'd1);
        release_result();

        // Async reset after 3 RUN edges.
        bus.A     = 8'h03;
        bus.B     = 8'h04;
        bus.Cin   = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        check("mid_run_sum", 32'(bus.SUM), 32'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(bus.out_valid), 32'd0);
        check("async_rst_sum", 32'(bus.SUM), 32'd0);
        check("async_rst_cout", 32'(bus.COUT), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        accept_and_wait(8'h01, 8'h01, 1'b0);
        check("post_rst_sum", 32'(bus.SUM), 32'h02);
        check("post_rst_cout", 32'(bus.COUT), 32'd0);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
